// File: rtl/mem_instr_seq.sv
// Purpose : control sequencer for ld / ldi / st; drives the DataPath control strobes.
// Latency : T0 in the cycle after run is sampled; done at +9 (ld/st) or +7 (ldi), +1 per mem_ready=0 cycle.
// Backpres: stalls in T1 / T6(ld) / T7(st) until mem_ready, aborting to ERR after WAIT_MAX cycles (0 = wait forever).
//
// Ports: clock/clear (async active-low reset), run (start), ir (instruction register),
//        mem_ready (memory handshake), DataPath strobes (combinational from state, op_q, mem_ready),
//        busy/done (status), illegal/mem_err (sticky error flags, cleared by the next start from IDLE).
module mem_instr_seq #(
    parameter int          DATA_W   = 32,
    parameter logic [4:0]  OP_LD    = 5'b00000,
    parameter logic [4:0]  OP_LDI   = 5'b00001,
    parameter logic [4:0]  OP_ST    = 5'b00010,
    parameter int          WAIT_MAX = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              run,
    input  logic [DATA_W-1:0] ir,
    input  logic              mem_ready,
    output logic              PCout,
    output logic              MARin,
    output logic              IncPC,
    output logic              Zin,
    output logic              PCin,
    output logic              MDRin,
    output logic              IRin,
    output logic              MDRout,
    output logic              ram_read,
    output logic              ram_write,
    output logic              MD_read,
    output logic              Gra,
    output logic              Grb,
    output logic              BAout,
    output logic              Rin,
    output logic              Rout,
    output logic              Yin,
    output logic              Cout,
    output logic              Zlowout,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              mem_err
);

    // A zero WAIT_MAX would give a zero-width counter; keep one bit and disable the timeout instead.
    localparam int              CNT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam bit              TMO_EN   = (WAIT_MAX != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;

    logic [4:0] ir_op;
    logic       ir_legal;
    logic       is_ld;
    logic       is_ldi;
    logic       tmo;

    assign ir_op    = ir[DATA_W-1 -: 5];
    assign ir_legal = (ir_op == OP_LD) || (ir_op == OP_LDI) || (ir_op == OP_ST);
    assign is_ld    = (op_q == OP_LD);
    assign is_ldi   = (op_q == OP_LDI);
    // Timeout fires in the wait cycle whose count would reach WAIT_MAX.
    assign tmo      = TMO_EN && !mem_ready && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = '0;     // counter only survives while a wait state keeps stalling
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0; PCin = 1'b0;
        MDRin = 1'b0; IRin = 1'b0; MDRout = 1'b0; ram_read = 1'b0; ram_write = 1'b0;
        MD_read = 1'b0; Gra = 1'b0; Grb = 1'b0; BAout = 1'b0; Rin = 1'b0;
        Rout = 1'b0; Yin = 1'b0; Cout = 1'b0; Zlowout = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d   = S_T0;
                    illegal_d = 1'b0;
                    mem_err_d = 1'b0;
                end
            end
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                if (mem_ready) begin
                    ram_read = 1'b1; Zlowout = 1'b1; PCin = 1'b1; MD_read = 1'b1; MDRin = 1'b1;
                    state_d  = S_T2;
                end else if (tmo) begin
                    mem_err_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    ram_read = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                // Opcode is captured here only; ir is ignored in every other state.
                op_d = ir_op;
                if (!ir_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    state_d = S_T4;
                end
            end
            S_T4: begin
                Cout = 1'b1; Zin = 1'b1;
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_ldi) begin
                    Gra = 1'b1; Rin = 1'b1;
                    state_d = S_DONE;
                end else begin
                    MARin   = 1'b1;
                    state_d = S_T6;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    if (mem_ready) begin
                        ram_read = 1'b1; MD_read = 1'b1; MDRin = 1'b1;
                        state_d  = S_T7;
                    end else if (tmo) begin
                        mem_err_d = 1'b1;
                        state_d   = S_ERR;
                    end else begin
                        ram_read = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // st: register value into MDR with MD_read low (select bus, not memory)
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    state_d = S_T7;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    state_d = S_DONE;
                end else if (mem_ready) begin
                    ram_write = 1'b1;
                    state_d   = S_DONE;
                end else if (tmo) begin
                    mem_err_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    ram_write = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: state_d = run ? S_T0 : S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mem_instr_seq.sv
// Purpose : checks mem_instr_seq cycle by cycle against a queue of expected outputs built from the instruction rules.
// Latency : every cycle of every instruction is compared, so start latency and stall lengths are checked implicitly.
// Backpres: mem_ready is held low for random stretches, including past the WAIT_MAX timeout.
module tb_mem_instr_seq;

    localparam int WMAX = 4;

    // Strobe positions inside the 19-bit expected strobe word
    localparam logic [18:0] PCOUT  = 19'd1 << 18;
    localparam logic [18:0] MARIN  = 19'd1 << 17;
    localparam logic [18:0] INCPC  = 19'd1 << 16;
    localparam logic [18:0] ZIN    = 19'd1 << 15;
    localparam logic [18:0] PCIN   = 19'd1 << 14;
    localparam logic [18:0] MDRIN  = 19'd1 << 13;
    localparam logic [18:0] IRIN   = 19'd1 << 12;
    localparam logic [18:0] MDROUT = 19'd1 << 11;
    localparam logic [18:0] RAMRD  = 19'd1 << 10;
    localparam logic [18:0] RAMWR  = 19'd1 << 9;
    localparam logic [18:0] MDRD   = 19'd1 << 8;
    localparam logic [18:0] GRA    = 19'd1 << 7;
    localparam logic [18:0] GRB    = 19'd1 << 6;
    localparam logic [18:0] BAOUT  = 19'd1 << 5;
    localparam logic [18:0] RIN    = 19'd1 << 4;
    localparam logic [18:0] ROUT   = 19'd1 << 3;
    localparam logic [18:0] YIN    = 19'd1 << 2;
    localparam logic [18:0] COUT   = 19'd1 << 1;
    localparam logic [18:0] ZLOW   = 19'd1 << 0;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout, ram_read, ram_write;
    logic MD_read, Gra, Grb, BAout, Rin, Rout, Yin, Cout, Zlowout;
    logic busy, done, illegal, mem_err;

    mem_instr_seq #(.DATA_W(32), .WAIT_MAX(WMAX)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .MDRout(MDRout), .ram_read(ram_read),
        .ram_write(ram_write), .MD_read(MD_read), .Gra(Gra), .Grb(Grb),
        .BAout(BAout), .Rin(Rin), .Rout(Rout), .Yin(Yin), .Cout(Cout),
        .Zlowout(Zlowout), .busy(busy), .done(done), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    logic [22:0] obs;
    assign obs = {PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout, ram_read, ram_write,
                  MD_read, Gra, Grb, BAout, Rin, Rout, Yin, Cout, Zlowout,
                  busy, done, illegal, mem_err};

    typedef struct {
        bit          run;
        bit          mr;
        logic [31:0] irv;
        logic [22:0] exp;
        int          inst;
        int          cyc;
    } cyc_t;

    cyc_t q[$];
    bit   ill_m = 1'b0;     // model of the sticky illegal flag
    bit   err_m = 1'b0;     // model of the sticky mem_err flag
    bit   last_done = 1'b0; // last queued cycle is a DONE cycle
    int   inst_i = 0;
    int   cyc_i = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] rir();
        return $urandom;
    endfunction

    task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic push(input bit r, input bit m, input logic [31:0] iv,
                        input logic [18:0] s, input bit b, input bit d);
        cyc_t c;
        c.run  = r;
        c.mr   = m;
        c.irv  = iv;
        c.exp  = {s, b, d, ill_m, err_m};
        c.inst = inst_i;
        c.cyc  = cyc_i;
        cyc_i++;
        q.push_back(c);
    endtask

    // A memory access that sees d cycles of mem_ready=0 before mem_ready=1.
    task automatic wait_phase(input int d, input logic [18:0] req, input logic [18:0] extra,
                              input logic [31:0] iv, output bit to);
        to = 1'b0;
        if (d >= WMAX) begin
            for (int k = 0; k < WMAX - 1; k++) push(1'b0, 1'b0, iv, req, 1'b1, 1'b0);
            push(1'b0, 1'b0, iv, '0, 1'b1, 1'b0);          // timeout cycle: request dropped
            err_m = 1'b1;
            push(1'b0, rbit(), rir(), '0, 1'b1, 1'b0);      // ERR
            to = 1'b1;
        end else begin
            for (int k = 0; k < d; k++) push(1'b0, 1'b0, iv, req, 1'b1, 1'b0);
            push(1'b0, 1'b1, iv, req | extra, 1'b1, 1'b0);
        end
    endtask

    // Queue one instruction: d1 = stall cycles at fetch, d2 = stall cycles at the data access.
    task automatic add_instr(input logic [31:0] iv, input int d1, input int d2, input bit b2b);
        logic [4:0] op;
        bit         t;
        cyc_t       c;
        op = iv[31:27];
        inst_i++;
        cyc_i = 0;
        if (b2b && last_done && q.size() > 0) begin
            c = q.pop_back();
            c.run = 1'b1;
            q.push_back(c);
        end else begin
            push(1'b1, rbit(), rir(), '0, 1'b0, 1'b0);     // IDLE with run
            ill_m = 1'b0;
            err_m = 1'b0;
        end
        last_done = 1'b0;
        push(1'b0, rbit(), iv, PCOUT | MARIN | INCPC | ZIN, 1'b1, 1'b0);
        wait_phase(d1, RAMRD, ZLOW | PCIN | MDRD | MDRIN, iv, t);
        if (t) return;
        push(1'b0, rbit(), iv, MDROUT | IRIN, 1'b1, 1'b0);
        if (!(op inside {5'd0, 5'd1, 5'd2})) begin
            push(1'b0, rbit(), iv, '0, 1'b1, 1'b0);
            ill_m = 1'b1;
            push(1'b0, rbit(), rir(), '0, 1'b1, 1'b0);      // ERR
            return;
        end
        push(1'b0, rbit(), iv, GRB | BAOUT | YIN, 1'b1, 1'b0);
        // ir changes freely from here on and must be ignored
        push(1'b0, rbit(), rir(), COUT | ZIN, 1'b1, 1'b0);
        if (op == 5'd1) begin
            push(1'b0, rbit(), rir(), ZLOW | GRA | RIN, 1'b1, 1'b0);
        end else begin
            push(1'b0, rbit(), rir(), ZLOW | MARIN, 1'b1, 1'b0);
            if (op == 5'd0) begin
                wait_phase(d2, RAMRD, MDRD | MDRIN, rir(), t);
                if (t) return;
                push(1'b0, rbit(), rir(), MDROUT | GRA | RIN, 1'b1, 1'b0);
            end else begin
                push(1'b0, rbit(), rir(), GRA | ROUT | MDRIN, 1'b1, 1'b0);
                wait_phase(d2, RAMWR, '0, rir(), t);
                if (t) return;
            end
        end
        push(1'b0, rbit(), rir(), '0, 1'b1, 1'b1);          // DONE
        last_done = 1'b1;
    endtask

    task automatic play(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            @(posedge clock);
            #1;
            run       = c.run;
            mem_ready = c.mr;
            ir        = c.irv;
            @(negedge clock);
            check($sformatf("instr%0d_cyc%0d", c.inst, c.cyc), obs, c.exp);
        end
    endtask

    initial begin
        logic [31:0] iv;
        int          r;
        int          d1;
        int          d2;
        bit          b2b;

        // Reset: outputs must stay low even with run and mem_ready high
        run = 1'b1;
        mem_ready = 1'b1;
        ir = 32'h0310_0063;
        #1 check("reset_t1", obs, '0);
        #11 check("reset_t12", obs, '0);
        run = 1'b0;
        mem_ready = 1'b0;
        #10 clear = 1'b1;

        // Directed: ld, back-to-back ldi, st with 3-cycle write stall, illegal, fetch timeout,
        // restart after error, store timeout, load data stall
        add_instr(32'h0310_0063, 0, 0, 1'b0);
        add_instr(32'h0A00_0054, 0, 0, 1'b1);
        add_instr(32'h1198_0090, 0, 3, 1'b0);
        add_instr(32'hF800_0000, 0, 0, 1'b0);
        add_instr(32'h0310_0063, 5, 0, 1'b0);
        add_instr(32'h0310_0063, 2, 1, 1'b0);
        add_instr(32'h1198_0090, 0, 4, 1'b1);
        add_instr(32'h0310_0063, 1, 3, 1'b0);
        add_instr(32'h0A00_0054, 3, 0, 1'b1);
        play(q.size());

        // Asynchronous clear in the middle of a ld data wait (T6)
        add_instr(32'h0310_0063, 0, 2, 1'b0);
        play(8);
        #2;
        clear = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        #1 check("async_clear", obs, '0);
        q.delete();
        ill_m = 1'b0;
        err_m = 1'b0;
        last_done = 1'b0;
        @(posedge clock);
        #1 check("clear_held", obs, '0);
        @(negedge clock);
        #1 clear = 1'b1;
        add_instr(32'h0310_0063, 0, 0, 1'b0);
        play(q.size());

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 7);
            iv = rir();
            if (r <= 2)      iv[31:27] = 5'd0;
            else if (r <= 4) iv[31:27] = 5'd1;
            else if (r <= 6) iv[31:27] = 5'd2;
            else             iv[31:27] = 5'($urandom_range(3, 31));
            d1 = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
            d2 = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
            b2b = rbit();
            if (!b2b && $urandom_range(0, 3) == 0) begin
                push(1'b0, rbit(), rir(), '0, 1'b0, 1'b0);  // idle gap
                last_done = 1'b0;
            end
            add_instr(iv, d1, d2, b2b);
        end
        play(q.size());

        @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_instr_seq.md
# mem_instr_seq

Parametrised control sequencer for the memory-format instructions ld, ldi and st. It issues the fetch and execute control strobes to the DataPath, which the directed load benches currently drive by hand. It adds three things those hand-written sequences lack: a memory-ready handshake with a timeout, decoding of all three opcodes, and a start/done/error handshake towards the top level. It sits between the top level and DataPath and drives the DataPath control inputs of the same names.

## Interface
- DATA_W, 32: instruction width; the opcode is ir[DATA_W-1 -: 5].
- OP_LD, 5'b00000: ld opcode.
- OP_LDI, 5'b00001: ldi opcode.
- OP_ST, 5'b00010: st opcode.
- WAIT_MAX, 15: maximum mem_ready wait cycles per memory access; 0 disables the timeout.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset (0 = reset).
- run  in  1  start request, sampled in IDLE and DONE.
- ir  in  DATA_W  IR contents from DataPath.
- mem_ready  in  1  memory has completed the current read or write.
- PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout, ram_read, ram_write, MD_read, Gra, Grb, BAout, Rin, Rout, Yin, Cout, Zlowout  out  1 each  DataPath control strobes.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  sticky: the decoded opcode was not ld, ldi or st.
- mem_err  out  1  sticky: the mem_ready timeout expired.

## Operation
- States: IDLE, T0–T7, DONE, ERR.
- Strobes are combinational from state, op_q and mem_ready. Any strobe not listed for a state is 0.
- IDLE: run=1 → T0, and clears illegal and mem_err.
- T0: PCout, MARin, IncPC, Zin → T1.
- T1: ram_read=1 every cycle. In the cycle mem_ready=1, also Zlowout, PCin, MD_read, MDRin, then → T2. Otherwise stay in T1.
- T2: MDRout, IRin → T3.
- T3: op_q <= opcode field of ir.
  - Opcode not in {OP_LD, OP_LDI, OP_ST}: illegal <= 1, → ERR, no strobes.
  - Otherwise: Grb, BAout, Yin → T4. BAout makes base register R0 read as 0.
- T4: Cout, Zin (effective address = Y + sign-extended C) → T5.
- T5:
  - ldi: Zlowout, Gra, Rin → DONE.
  - ld/st: Zlowout, MARin → T6.
- T6:
  - ld: ram_read every cycle. On mem_ready=1, also MD_read, MDRin → T7.
  - st: Gra, Rout, MDRin with MD_read=0 → T7.
- T7:
  - ld: MDRout, Gra, Rin → DONE.
  - st: ram_write every cycle; on mem_ready=1 → DONE.
- DONE: done=1. run=1 → T0, otherwise → IDLE.
- ERR: one cycle, then → IDLE. The sticky flags stay set.
- Wait counter, width $clog2(WAIT_MAX+1):
  - Reset to 0 on entry to T1, T6(ld) and T7(st).
  - Increments each cycle mem_ready=0 in those states.
  - If it reaches WAIT_MAX while mem_ready=0: mem_err <= 1, → ERR, and the read/write strobe drops that cycle.
  - WAIT_MAX=0: waits indefinitely.

## Timing
- Reset (clear=0, asynchronous): state=IDLE, op_q=0, counter=0, illegal=0, mem_err=0. All strobes, busy and done are 0 immediately.
- Reset mid-instruction aborts at once; no strobe persists after clear falls.
- Latency, from run sampled high at edge k with mem_ready held at 1:
  - T0 is active in cycle k+1.
  - ld and st: done in cycle k+9.
  - ldi: done in cycle k+7.
  - Each mem_ready=0 cycle adds one cycle.
- Back-to-back operation: run=1 in DONE gives T0 in the next cycle, with no IDLE gap.
- mem_ready outside T1, T6(ld) and T7(st) is ignored.
- ir is sampled only in T3; later changes to ir have no effect.
- done and ERR are mutually exclusive per instruction.
- A timeout abandons the instruction: PC has already been incremented only if the timeout happened after T1.

## Test plan
- ld R6,0x63(R2), ir=0x03100063, R2 preloaded 0x78, mem_ready=1, RAM[0xDB]=0x12345678 → strobe sequence exactly as T0–T7; MAR=0xDB in T6; R6=0x12345678; done in cycle k+9.
- ldi R4,0x54(R0), ir=0x0A000054 → BAout in T3; R4=0x54; done in cycle k+7; no ram_read after T1.
- st 0x90(R3),R7 with R3=0x10, R7=0xCAFE, mem_ready delayed 3 cycles in T7 → ram_write high for 4 cycles; RAM[0xA0]=0xCAFE; done in cycle k+12.
- Opcode 5'b11111 in ir → illegal=1 after T3; ERR then IDLE; no Rin or ram_write asserted; next run clears illegal.
- WAIT_MAX=4, mem_ready stuck at 0 in T1 → mem_err=1 on the fourth wait cycle; ram_read falls that cycle; ERR → IDLE.
- clear pulsed low during T6 of a ld → all outputs 0 asynchronously; IDLE afterwards; run restarts cleanly from T0.
